// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and FSM encoding for the 1-to-4 demultiplexer.
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/demux_sat_counter.sv
// demux_sat_counter: per-channel delivered-transfer counter that sticks at all-ones.
module demux_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Step by one on inc, but never wrap past the all-ones ceiling.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Counter register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/demux_1x4.sv
// demux_1x4: single-entry holding register that steers one payload to one of
// four ready/valid sinks. Optional per-channel delivery counters are built
// only when the macro DEMUX_STATS_EN is defined.
module demux_1x4
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_W-1:0]       out_data,
    output logic [NUM_CH-1:0]       out_valid,
    input  logic [NUM_CH-1:0]       out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0] stat_cnt
`endif
);

    state_t            state_q;
    state_t            state_d;
    logic [DATA_W-1:0] hold_data_q;
    logic [DATA_W-1:0] hold_data_d;
    logic [SEL_W-1:0]  hold_sel_q;
    logic [SEL_W-1:0]  hold_sel_d;

    logic              sel_ready;
    logic              accept;
    logic              drain;

    // Only the sink addressed by the held entry can free the register; the
    // other out_ready bits are deliberately ignored.
    always_comb begin
        sel_ready = out_ready[hold_sel_q];
        in_ready  = !rst && ((state_q == EMPTY) || sel_ready);
        accept    = in_valid && in_ready;
        drain     = (state_q == FULL) && sel_ready;
    end

    // Next-state and holding-register load: a drain and an accept in the same
    // cycle keep the FSM FULL with the new entry, giving one transfer per cycle.
    always_comb begin
        state_d     = state_q;
        hold_data_d = hold_data_q;
        hold_sel_d  = hold_sel_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d     = FULL;
                    hold_data_d = in_data;
                    hold_sel_d  = in_sel;
                end
            end
            FULL: begin
                if (drain) begin
                    if (accept) begin
                        state_d     = FULL;
                        hold_data_d = in_data;
                        hold_sel_d  = in_sel;
                    end else begin
                        state_d     = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // State and holding register; reset discards any held entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            hold_data_q <= '0;
            hold_sel_q  <= '0;
        end else begin
            state_q     <= state_d;
            hold_data_q <= hold_data_d;
            hold_sel_q  <= hold_sel_d;
        end
    end

    // One-hot valid decoded purely from registered state, so no input reaches
    // the outputs combinationally.
    always_comb begin
        out_valid = '0;
        if (state_q == FULL) begin
            out_valid[hold_sel_q] = 1'b1;
        end
    end

    assign out_data = hold_data_q;

`ifdef DEMUX_STATS_EN
    for (genvar k = 0; k < NUM_CH; k++) begin : g_stats
        logic inc;
        assign inc = drain && (hold_sel_q == SEL_W'(k));

        demux_sat_counter #(
            .CNT_W (CNT_W)
        ) u_cnt (
            .clk   (clk),
            .rst   (rst),
            .inc   (inc),
            .count (stat_cnt[k*CNT_W +: CNT_W])
        );
    end
`endif

endmodule
